// File: rtl/selecting_machine_core.sv
// Multi-channel slot machine core: rolling digit counters, synchronised start/stop
// edges, game-result flags and a time-multiplexed common-cathode scan output.
module selecting_machine_core #(
  parameter int CH        = 6,
  parameter int DW        = 4,
  parameter int MOD       = 10,
  parameter int TICK_BASE = 1250000,
  parameter int TICK_STEP = 250000,
  parameter int SCAN_DIV  = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CH-1:0]    btn,
  output logic [CH*DW-1:0] code,
  output logic [CH-1:0]    running,
  output logic             all_stopped,
  output logic             match,
  output logic [2:0]       scan_idx,
  output logic [CH-1:0]    digit_cath,
  output logic [DW-1:0]    digit_val
);

  localparam int NI   = CH + 1;
  localparam int PMAX = TICK_BASE + (CH - 1) * TICK_STEP;
  localparam int TW   = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam int SW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [NI-1:0] sync1_q, sync1_d;
  logic [NI-1:0] sync2_q, sync2_d;
  logic [NI-1:0] sync3_q, sync3_d;
  logic [NI-1:0] edge_q, edge_d;
  logic [1:0]    prime_q, prime_d;

  logic [TW-1:0] tick_cnt_q [CH];
  logic [TW-1:0] tick_cnt_d [CH];
  logic [CH-1:0] tick;

  logic [DW-1:0] code_q [CH];
  logic [DW-1:0] code_d [CH];
  logic [CH-1:0] running_q, running_d;
  logic          all_stopped_q, all_stopped_d;
  logic          match_q, match_d;
  logic          all_eq;

  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic          scan_tick;
  logic [2:0]    scan_idx_q, scan_idx_d;
  logic [CH-1:0] digit_cath_q, digit_cath_d;
  logic [DW-1:0] digit_val_q, digit_val_d;

  logic          start_edge;
  logic [CH-1:0] btn_edge;

  // Edges stay masked until the sync chain holds real samples, so a level held
  // high through reset is not mistaken for a fresh rising edge.
  always_comb begin
    sync1_d = {btn, start};
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    prime_d = (prime_q == 2'd3) ? prime_q : prime_q + 2'd1;
    edge_d  = (prime_q == 2'd3) ? (sync2_q & ~sync3_q) : '0;
  end

  assign start_edge = edge_q[0];
  assign btn_edge   = edge_q[NI-1:1];

  always_comb begin
    tick = '0;
    for (int i = 0; i < CH; i++) begin
      tick[i]       = (tick_cnt_q[i] == TW'(TICK_BASE + i * TICK_STEP - 1));
      tick_cnt_d[i] = tick[i] ? '0 : tick_cnt_q[i] + TW'(1);
    end
  end

  // Start overrides a same-cycle stop; a stop suppresses a same-cycle advance.
  always_comb begin
    running_d = start_edge ? '1 : (running_q & ~btn_edge);
    for (int i = 0; i < CH; i++) begin
      code_d[i] = code_q[i];
      if (tick[i] && running_q[i] && !btn_edge[i]) begin
        code_d[i] = (code_q[i] == DW'(MOD - 1)) ? '0 : code_q[i] + DW'(1);
      end
    end
  end

  always_comb begin
    all_eq = 1'b1;
    for (int i = 1; i < CH; i++) begin
      if (code_q[i] != code_q[0]) begin
        all_eq = 1'b0;
      end
    end
    all_stopped_d = ~|running_q;
    match_d       = ~|running_q & all_eq;
  end

  // Cathode and value are both derived from the next slot index so they switch together.
  always_comb begin
    scan_tick  = (scan_cnt_q == SW'(SCAN_DIV - 1));
    scan_cnt_d = scan_tick ? '0 : scan_cnt_q + SW'(1);
    scan_idx_d = scan_idx_q;
    if (scan_tick) begin
      scan_idx_d = (scan_idx_q == 3'(CH - 1)) ? 3'd0 : scan_idx_q + 3'd1;
    end
    digit_cath_d = '1;
    digit_val_d  = '0;
    for (int i = 0; i < CH; i++) begin
      if (scan_idx_d == 3'(i)) begin
        digit_cath_d[i] = 1'b0;
        digit_val_d     = code_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      sync3_q       <= '0;
      edge_q        <= '0;
      prime_q       <= '0;
      running_q     <= '0;
      all_stopped_q <= 1'b1;
      match_q       <= 1'b1;
      scan_cnt_q    <= '0;
      scan_idx_q    <= '0;
      digit_cath_q  <= {{(CH-1){1'b1}}, 1'b0};
      digit_val_q   <= '0;
      for (int i = 0; i < CH; i++) begin
        tick_cnt_q[i] <= '0;
        code_q[i]     <= '0;
      end
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      sync3_q       <= sync3_d;
      edge_q        <= edge_d;
      prime_q       <= prime_d;
      running_q     <= running_d;
      all_stopped_q <= all_stopped_d;
      match_q       <= match_d;
      scan_cnt_q    <= scan_cnt_d;
      scan_idx_q    <= scan_idx_d;
      digit_cath_q  <= digit_cath_d;
      digit_val_q   <= digit_val_d;
      for (int i = 0; i < CH; i++) begin
        tick_cnt_q[i] <= tick_cnt_d[i];
        code_q[i]     <= code_d[i];
      end
    end
  end

  always_comb begin
    code = '0;
    for (int i = 0; i < CH; i++) begin
      code[i*DW +: DW] = code_q[i];
    end
  end

  assign running     = running_q;
  assign all_stopped = all_stopped_q;
  assign match       = match_q;
  assign scan_idx    = scan_idx_q;
  assign digit_cath  = digit_cath_q;
  assign digit_val   = digit_val_q;

endmodule

// File: tb/tb_selecting_machine_core.sv
// Randomised and directed bench for selecting_machine_core, checked every cycle
// against a cycle-count based behavioural model of the slot machine.
module tb_selecting_machine_core;

  localparam int CH  = 3;
  localparam int DW  = 4;
  localparam int MOD = 10;
  localparam int TB  = 4;
  localparam int TS  = 2;
  localparam int SD  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [CH-1:0]    btn = '0;
  logic [CH*DW-1:0] code;
  logic [CH-1:0]    running;
  logic             all_stopped;
  logic             match;
  logic [2:0]       scan_idx;
  logic [CH-1:0]    digit_cath;
  logic [DW-1:0]    digit_val;

  int checks = 0;
  int failures = 0;

  // Model: k counts clock edges since reset release; hist holds {btn,start} sampled at each edge.
  int            k;
  logic [CH:0]   hist[$];
  int            m_code[CH];
  logic [CH-1:0] m_run;
  logic          m_alls;
  logic          m_match;
  int            m_scan;
  logic [CH-1:0] m_cath;
  int            m_dval;

  selecting_machine_core #(
    .CH(CH), .DW(DW), .MOD(MOD), .TICK_BASE(TB), .TICK_STEP(TS), .SCAN_DIV(SD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .btn(btn),
    .code(code), .running(running), .all_stopped(all_stopped), .match(match),
    .scan_idx(scan_idx), .digit_cath(digit_cath), .digit_val(digit_val)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h (t=%0t k=%0d)", tag, got, exp, $time, k);
    end
  endtask

  task automatic modelReset();
    k = 0;
    hist.delete();
    for (int i = 0; i < CH; i++) m_code[i] = 0;
    m_run   = '0;
    m_alls  = 1'b1;
    m_match = 1'b1;
    m_scan  = 0;
    m_cath  = '1;
    m_cath[0] = 1'b0;
    m_dval  = 0;
  endtask

  // An input edge takes effect three edges after the first high sample, and only
  // when both the low and the high sample were taken after reset release.
  function automatic bit riseAt(int bitn);
    if (k < 5) return 1'b0;
    return hist[k-4][bitn] && !hist[k-5][bitn];
  endfunction

  task automatic modelStep();
    int            nc[CH];
    logic [CH-1:0] br;
    logic          sr;
    bit            eq;
    int            ns;
    k++;
    hist.push_back({btn, start});
    sr = riseAt(0);
    for (int i = 0; i < CH; i++) br[i] = riseAt(i + 1);
    eq = 1'b1;
    for (int i = 0; i < CH; i++) begin
      nc[i] = m_code[i];
      if ((k % (TB + i * TS)) == 0 && m_run[i] && !br[i]) nc[i] = (m_code[i] + 1) % MOD;
      if (m_code[i] != m_code[0]) eq = 1'b0;
    end
    ns = ((k % SD) == 0) ? (m_scan + 1) % CH : m_scan;
    m_alls  = (m_run == '0);
    m_match = (m_run == '0) && eq;
    m_dval  = m_code[ns];
    m_cath  = '1;
    m_cath[ns] = 1'b0;
    m_scan  = ns;
    m_run   = sr ? '1 : (m_run & ~br);
    for (int i = 0; i < CH; i++) m_code[i] = nc[i];
  endtask

  task automatic checkAll();
    logic [CH*DW-1:0] ec;
    for (int i = 0; i < CH; i++) ec[i*DW +: DW] = DW'(m_code[i]);
    checkOutput("code", 32'(code), 32'(ec));
    checkOutput("running", 32'(running), 32'(m_run));
    checkOutput("all_stopped", 32'(all_stopped), 32'(m_alls));
    checkOutput("match", 32'(match), 32'(m_match));
    checkOutput("scan_idx", 32'(scan_idx), 32'(m_scan));
    checkOutput("digit_cath", 32'(digit_cath), 32'(m_cath));
    checkOutput("digit_val", 32'(digit_val), 32'(m_dval));
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic applyStimulus(input logic s, input logic [CH-1:0] b);
    start = s;
    btn   = b;
    @(posedge clk);
    #1;
    modelStep();
    checkAll();
    @(negedge clk);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_code"}, 32'(code), 32'h0);
    checkOutput({tag, "_running"}, 32'(running), 32'h0);
    checkOutput({tag, "_all_stopped"}, 32'(all_stopped), 32'h1);
    checkOutput({tag, "_match"}, 32'(match), 32'h1);
    checkOutput({tag, "_scan_idx"}, 32'(scan_idx), 32'h0);
    checkOutput({tag, "_digit_cath"}, 32'(digit_cath), 32'b110);
    checkOutput({tag, "_digit_val"}, 32'(digit_val), 32'h0);
  endtask

  task automatic doReset(input logic hold_start);
    #2 rst = 1'b0;
    #1 checkReset("rst");
    modelReset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      btn   = CH'($urandom);
      start = ~start;
    end
    @(negedge clk);
    start = hold_start;
    btn   = '0;
    checkReset("rst_hold");
    rst = 1'b1;
  endtask

  initial begin
    int exp_c;
    int guard;
    logic s;
    logic [CH-1:0] b;
    modelReset();
    @(negedge clk);
    doReset(1'b0);

    // All channels stopped straight after start: codes still zero.
    applyStimulus(1'b0, 3'b000);
    applyStimulus(1'b1, 3'b000);
    for (int n = 0; n < 7; n++) applyStimulus(1'b1, 3'b111);
    checkOutput("match_equal", 32'(match), 32'h1);
    checkOutput("match_all_stopped", 32'(all_stopped), 32'h1);
    checkOutput("match_code_zero", 32'(code), 32'h0);

    // Free run long enough for channel 0 to wrap.
    for (int n = 0; n < 3; n++) applyStimulus(1'b0, 3'b000);
    for (int n = 0; n < 48; n++) applyStimulus(1'b1, 3'b000);

    // Stop channel 1, then re-raise its button.
    for (int n = 0; n < 10; n++) applyStimulus(1'b1, 3'b010);
    checkOutput("stop_ch1", 32'(running[1]), 32'h0);
    exp_c = m_code[1];
    for (int n = 0; n < 3; n++) applyStimulus(1'b1, 3'b000);
    for (int n = 0; n < 6; n++) applyStimulus(1'b1, 3'b010);
    checkOutput("frozen_ch1", 32'(code[1*DW +: DW]), 32'(exp_c));

    // Start edge and btn[0] edge in the same cycle.
    for (int n = 0; n < 3; n++) applyStimulus(1'b0, 3'b000);
    for (int n = 0; n < 6; n++) applyStimulus(1'b1, 3'b001);
    checkOutput("collide_run0", 32'(running[0]), 32'h1);

    // btn[2] edge landing on a channel-2 tick.
    guard = 0;
    while (((k + 4) % (TB + 2 * TS)) != 0 && guard < 16) begin
      applyStimulus(1'b1, 3'b001);
      guard++;
    end
    checkOutput("align_guard", 32'(guard < 16), 32'h1);
    for (int n = 0; n < 3; n++) applyStimulus(1'b1, 3'b101);
    exp_c = m_code[2];
    for (int n = 0; n < 5; n++) applyStimulus(1'b1, 3'b101);
    checkOutput("stop_tick_ch2", 32'(code[2*DW +: DW]), 32'(exp_c));
    checkOutput("stop_tick_run2", 32'(running[2]), 32'h0);

    // Stop the remaining channels with whatever codes they hold.
    for (int n = 0; n < 2; n++) applyStimulus(1'b1, 3'b000);
    for (int n = 0; n < 8; n++) applyStimulus(1'b1, 3'b111);

    // Mid-operation reset, then scan sequencing.
    doReset(1'b0);
    applyStimulus(1'b0, 3'b000);
    applyStimulus(1'b0, 3'b000);
    checkOutput("scan1_idx", 32'(scan_idx), 32'h1);
    checkOutput("scan1_cath", 32'(digit_cath), 32'b101);
    applyStimulus(1'b0, 3'b000);
    applyStimulus(1'b0, 3'b000);
    checkOutput("scan2_idx", 32'(scan_idx), 32'h2);
    checkOutput("scan2_cath", 32'(digit_cath), 32'b011);
    applyStimulus(1'b0, 3'b000);
    applyStimulus(1'b0, 3'b000);
    checkOutput("scan0_idx", 32'(scan_idx), 32'h0);
    checkOutput("scan0_cath", 32'(digit_cath), 32'b110);

    // Start held high through reset must not start the channels.
    doReset(1'b1);
    for (int n = 0; n < 10; n++) applyStimulus(1'b1, 3'b000);
    checkOutput("held_start_idle", 32'(running), 32'h0);

    // Randomised operation with occasional resets.
    s = start;
    b = btn;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        doReset(s);
      end
      if ($urandom_range(0, 19) == 0) s = ~s;
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 11) == 0) b[i] = ~b[i];
      end
      applyStimulus(s, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/selecting_machine_core.md
Name: selecting_machine_core

Overview:
Parametrised multi-channel selecting (slot) machine core. It holds CH rolling digit counters, each advancing at its own divided rate. Counters are started together, stopped individually by button rising edges, and time-multiplexed onto a common-cathode scan bus. The core also reports "all stopped" and "all channels match" for the game-result logic. Segment decoding and the lattice display sit downstream and are not part of this block.

Parameters:
CH, 6, number of channels/digits (2..8)
DW, 4, bits per channel code
MOD, 10, channel modulus; code counts 0..MOD-1 (MOD <= 2^DW)
TICK_BASE, 1250000, clk cycles between advances of channel 0
TICK_STEP, 250000, extra cycles per channel index; channel i period = TICK_BASE + i*TICK_STEP
SCAN_DIV, 50000, clk cycles per scan slot

Ports:
clk  input  1  system clock (50 MHz)
rst  input  1  asynchronous, active-low reset
start  input  1  async level; rising edge sets all channels running
btn  input  CH  async levels; rising edge on btn[i] stops channel i
code  output  CH*DW  packed channel codes, channel i at [i*DW +: DW]
running  output  CH  per-channel run flag
all_stopped  output  1  high when running == 0
match  output  1  high when all_stopped and all codes are equal
scan_idx  output  3  channel currently driven on the scan bus
digit_cath  output  CH  active-low one-hot cathode select
digit_val  output  DW  code of channel scan_idx

Behaviour:
- Reset (rst low, asynchronous) values: code all 0, running 0, all_stopped 1, match 1, scan_idx 0, digit_cath = ~1 (bit0 low), digit_val 0. All divider and synchroniser flops clear.
- Input conditioning: start and each btn bit pass through 2-flop synchronisers plus an edge register. Rising edge = sync high and previous low. Edge pulse is 1 cycle, 3 clk after the input transition.
- Tick generators: one free-running counter per channel, 0..P_i-1 with P_i = TICK_BASE + i*TICK_STEP. Each emits a 1-cycle tick_i at terminal count. Counters run regardless of running state.
- Channel update on tick_i with running[i]=1: code_i <= (code_i == MOD-1) ? 0 : code_i+1. No tick, or running[i]=0: code_i holds.
- Start edge: running <= all ones on the next clk. Already-running channels are unaffected. Codes are not cleared.
- btn[i] edge: running[i] <= 0 on the next clk. Ignored if already stopped.
- Simultaneous events: start edge and btn[i] edge in the same cycle -> start wins, channel i stays running. btn[i] edge and tick_i in the same cycle -> stop wins, no increment.
- all_stopped and match are registered: 1 cycle after running/code change. match compares all CH codes for equality, gated by all_stopped.
- Scan: divider counts 0..SCAN_DIV-1. At terminal count scan_idx <= (scan_idx == CH-1) ? 0 : scan_idx+1. digit_cath and digit_val are registered from the new scan_idx in the same cycle, so they never show a mismatched channel/value pair. digit_val tracks live code changes while its slot is selected, with 1-cycle latency.
- Reset asserted mid-operation: immediate clear to reset values. After release, start must be edge-detected anew; a start held high through reset does not generate an edge.

Test Plan:
Parameters for all scenarios: CH=3, DW=4, MOD=10, TICK_BASE=4, TICK_STEP=2, SCAN_DIV=2.
- Reset: hold rst low, toggle btn/start -> code=0, running=000, all_stopped=1, match=1, digit_cath=110.
- Start and wrap: pulse start, run 40 clk -> channel 0 increments every 4 clk, channel 1 every 6, channel 2 every 8. Channel 0 goes 9->0.
- Stop: raise btn[1] while running -> running[1] clears 4 clk after the edge and code[1] then freezes. Re-raising btn[1] has no effect.
- Collision: start and btn[0] edge land in the same cycle -> running[0]=1. btn[2] edge coincident with tick_2 -> code[2] unchanged.
- Match: stop all channels when codes are equal (e.g. all 0 right after reset plus start, then immediate stops) -> all_stopped=1, match=1. With unequal codes -> match=0.
- Scan and reset: observe scan_idx 0,1,2,0 every 2 clk, with digit_cath 110,101,011 aligned to the matching digit_val. Drop rst mid-scan -> outputs return to reset values asynchronously.
